// File: rtl/reg_dec_pkg.sv
// Shared types and helpers for the register-file write-select decoder.
// Holds the FSM state enum, the wrapping increment and the parameter check.
package reg_dec_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Next register index, wrapping from the last register back to 0.
    function automatic int unsigned inc_wrap(
        input int unsigned addr,
        input int unsigned num_regs
    );
        return (addr == num_regs - 1) ? 0 : addr + 1;
    endfunction

    // True when the register count fits the address width.
    function automatic bit params_ok(
        input int num_regs,
        input int addr_w
    );
        return (num_regs >= 2) && (num_regs <= (1 << addr_w));
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational register index to one-hot write-select decoder.
// Ports: idx (index in), onehot (NUM_REGS one-hot out), in_range (idx < NUM_REGS).
module onehot_decoder
    import reg_dec_pkg::*;
#(
    parameter int NUM_REGS = 14,
    parameter int ADDR_W   = 4
) (
    input  logic [ADDR_W-1:0]   idx,
    output logic [NUM_REGS-1:0] onehot,
    output logic                in_range
);

    always_comb begin
        in_range = 32'(idx) < 32'(NUM_REGS);
        onehot   = '0;
        // Indices at or above NUM_REGS match no bit, so the vector stays zero.
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot[i] = (32'(idx) == 32'(i));
        end
    end

endmodule

// File: rtl/reg_wr_decoder.sv
// Register-file write-select decoder with burst auto-increment and wrap.
// Ports: clk, rst, flush, req_valid/req_ready/req_addr/req_len handshake, wr_en, err.
module reg_wr_decoder
    import reg_dec_pkg::*;
#(
    parameter int NUM_REGS = 14,
    parameter int ADDR_W   = 4,
    parameter int LEN_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [LEN_W-1:0]    req_len,
    output logic [NUM_REGS-1:0] wr_en,
    output logic                err
);

    if (!params_ok(NUM_REGS, ADDR_W)) begin : g_bad_params
        $error("reg_wr_decoder: NUM_REGS must be 2 .. 2**ADDR_W");
    end

    state_t              state;
    state_t              state_n;
    logic [ADDR_W-1:0]   cur_addr;
    logic [ADDR_W-1:0]   cur_n;
    logic [LEN_W-1:0]    rem;
    logic [LEN_W-1:0]    rem_n;
    logic [NUM_REGS-1:0] wr_en_q;
    logic [NUM_REGS-1:0] wr_n;
    logic                err_q;
    logic                err_n;

    logic [ADDR_W-1:0]   dec_idx;
    logic [NUM_REGS-1:0] dec_onehot;
    logic                dec_ok;
    logic                accept;

    assign req_ready = (state == IDLE) && !flush && !rst;
    assign accept    = req_valid && req_ready;

    // One decoder serves both the new request and the running burst.
    assign dec_idx = (state == BURST) ? cur_addr : req_addr;

    onehot_decoder #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_dec (
        .idx      (dec_idx),
        .onehot   (dec_onehot),
        .in_range (dec_ok)
    );

    always_comb begin
        state_n = state;
        cur_n   = cur_addr;
        rem_n   = rem;
        wr_n    = '0;
        err_n   = 1'b0;
        if (flush) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (dec_ok) begin
                            wr_n = dec_onehot;
                            if (req_len != '0) begin
                                state_n = BURST;
                                cur_n   = ADDR_W'(inc_wrap(32'(req_addr), NUM_REGS));
                                rem_n   = req_len;
                            end
                        end else begin
                            // Bad start index: flag it, drop req_len.
                            err_n = 1'b1;
                        end
                    end
                end
                BURST: begin
                    wr_n  = dec_onehot;
                    cur_n = ADDR_W'(inc_wrap(32'(cur_addr), NUM_REGS));
                    rem_n = rem - LEN_W'(1);
                    if (rem == LEN_W'(1)) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur_addr <= '0;
            rem      <= '0;
            wr_en_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            cur_addr <= cur_n;
            rem      <= rem_n;
            wr_en_q  <= wr_n;
            err_q    <= err_n;
        end
    end

    assign wr_en = wr_en_q;
    assign err   = err_q;

endmodule

// File: tb/tb_reg_wr_decoder.sv
// Directed table-driven bench for reg_wr_decoder (14 and 32 register builds).
// Ports: none; drives shared stimulus into both instances and checks one per row.
module tb_reg_wr_decoder;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic [4:0]  req_addr;
    logic [3:0]  req_len;

    logic        rdy_a;
    logic [13:0] wr_a;
    logic        err_a;
    logic        rdy_b;
    logic [31:0] wr_b;
    logic        err_b;

    reg_wr_decoder #(
        .NUM_REGS (14),
        .ADDR_W   (4),
        .LEN_W    (4)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (rdy_a),
        .req_addr  (req_addr[3:0]),
        .req_len   (req_len),
        .wr_en     (wr_a),
        .err       (err_a)
    );

    reg_wr_decoder #(
        .NUM_REGS (32),
        .ADDR_W   (5),
        .LEN_W    (4)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (rdy_b),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_en     (wr_b),
        .err       (err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One row is one clock cycle: inputs for that cycle, and the outputs
    // expected during it (flops reflect the previous row's inputs).
    typedef struct {
        logic        use_b;
        logic        rst;
        logic        flush;
        logic        valid;
        logic [4:0]  addr;
        logic [3:0]  len;
        logic [31:0] wr;
        logic        err;
        logic        rdy;
    } vec_t;

    vec_t tbl[$];
    int   checks;
    int   failures;

    function automatic logic [31:0] b(input int k);
        logic [31:0] one;
        one = 32'd1;
        return one << k;
    endfunction

    task automatic add(
        input logic        use_b,
        input logic        r,
        input logic        f,
        input logic        v,
        input int          a,
        input int          l,
        input logic [31:0] w,
        input logic        e,
        input logic        rd
    );
        vec_t x;
        x.use_b = use_b;
        x.rst   = r;
        x.flush = f;
        x.valid = v;
        x.addr  = 5'(a);
        x.len   = 4'(l);
        x.wr    = w;
        x.err   = e;
        x.rdy   = rd;
        tbl.push_back(x);
    endtask

    task automatic fill_a();
        // reset
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        // single writes 1..13 then 0, valid held
        for (int a = 1; a <= 13; a++) begin
            add(0, 0, 0, 1, a, 0, (a == 1) ? 32'd0 : b(a - 1), 0, 1);
        end
        add(0, 0, 0, 1, 0, 0, b(13), 0, 1);
        // burst 12 len 3 wraps 13 -> 0
        add(0, 0, 0, 1, 12, 3, b(0), 0, 1);
        add(0, 0, 0, 0, 0, 0, b(12), 0, 0);
        add(0, 0, 0, 0, 0, 0, b(13), 0, 0);
        add(0, 0, 0, 0, 0, 0, b(0), 0, 0);
        // out-of-range 14, 15 then addr 2 without delay
        add(0, 0, 0, 1, 14, 5, b(1), 0, 1);
        add(0, 0, 0, 1, 15, 0, 0, 1, 1);
        add(0, 0, 0, 1, 2, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, b(2), 0, 1);
        // burst 0 len 5, next request held, zero bubble
        add(0, 0, 0, 1, 0, 5, 0, 0, 1);
        for (int k = 0; k <= 4; k++) begin
            add(0, 0, 0, 1, 7, 0, b(k), 0, 0);
        end
        add(0, 0, 0, 1, 7, 0, b(5), 0, 1);
        add(0, 0, 0, 0, 0, 0, b(7), 0, 1);
        // flush in second burst cycle of 3 len 8
        add(0, 0, 0, 1, 3, 8, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, b(3), 0, 0);
        add(0, 0, 1, 1, 9, 0, b(4), 0, 0);
        add(0, 0, 0, 1, 9, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, b(9), 0, 1);
        // flush while idle blocks a held request for one cycle
        add(0, 0, 1, 1, 6, 0, 0, 0, 0);
        add(0, 0, 0, 1, 6, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, b(6), 0, 1);
        // reset mid-burst, then fresh request
        add(0, 0, 0, 1, 10, 6, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, b(10), 0, 0);
        add(0, 0, 0, 0, 0, 0, b(11), 0, 0);
        add(0, 1, 0, 1, 5, 0, b(12), 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 4, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, b(4), 0, 0);
        add(0, 0, 0, 0, 0, 0, b(5), 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic fill_b();
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int a = 1; a <= 31; a++) begin
            add(1, 0, 0, 1, a, 0, (a == 1) ? 32'd0 : b(a - 1), 0, 1);
        end
        add(1, 0, 0, 1, 0, 0, b(31), 0, 1);
        add(1, 0, 0, 1, 30, 3, b(0), 0, 1);
        add(1, 0, 0, 0, 0, 0, b(30), 0, 0);
        add(1, 0, 0, 0, 0, 0, b(31), 0, 0);
        add(1, 0, 0, 0, 0, 0, b(0), 0, 0);
        add(1, 0, 0, 0, 0, 0, b(1), 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        logic [31:0] got_wr;
        logic        got_err;
        logic        got_rdy;
        vec_t        v;

        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;

        fill_a();
        fill_b();

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(negedge clk);
            rst       = v.rst;
            flush     = v.flush;
            req_valid = v.valid;
            req_addr  = v.addr;
            req_len   = v.len;
            #1;
            if (v.use_b) begin
                got_wr  = wr_b;
                got_err = err_b;
                got_rdy = rdy_b;
            end else begin
                got_wr  = {18'd0, wr_a};
                got_err = err_a;
                got_rdy = rdy_a;
            end

            checks++;
            if (got_wr !== v.wr) begin
                failures++;
                $display("FAIL row%0d wr_en: got %h want %h", i, got_wr, v.wr);
            end
            checks++;
            if (got_err !== v.err) begin
                failures++;
                $display("FAIL row%0d err: got %b want %b", i, got_err, v.err);
            end
            checks++;
            if (got_rdy !== v.rdy) begin
                failures++;
                $display("FAIL row%0d req_ready: got %b want %b", i, got_rdy, v.rdy);
            end
            checks++;
            if (((got_wr & (got_wr - 32'd1)) != 32'd0) || ((got_wr != 32'd0) && got_err)) begin
                failures++;
                $display("FAIL row%0d onehot_excl: wr_en %h err %b want <=1 bit, not with err",
                         i, got_wr, got_err);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
